// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared helpers for the async FIFO pointer controllers (read and write side).
//   FIFO_PTR_MAX_W : widest pointer the Gray helpers handle.
//   ptr_width()    : pointer width for a given address width (one wrap bit extra).
//   bin2gray()     : binary to reflected Gray code.
//   gray2bin()     : reflected Gray code to binary.
// Callers zero-extend into FIFO_PTR_MAX_W and truncate the result. This is
// lossless because both conversions leave zero upper bits as zeros.
package fifo_rd_pkg;

  localparam int FIFO_PTR_MAX_W = 32;

  function automatic int ptr_width(input int rdepth);
    return rdepth + 1;
  endfunction

  function automatic logic [FIFO_PTR_MAX_W-1:0] bin2gray(input logic [FIFO_PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [FIFO_PTR_MAX_W-1:0] gray2bin(input logic [FIFO_PTR_MAX_W-1:0] gray);
    logic [FIFO_PTR_MAX_W-1:0] bin;
    bin[FIFO_PTR_MAX_W-1] = gray[FIFO_PTR_MAX_W-1];
    for (int i = FIFO_PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_ff.sv
// fifo_sync_ff
// Multi-bit flop-chain synchronizer. Use it only for Gray-coded buses, so that
// at most one bit changes in any source cycle.
//   pos_rclk     : destination clock
//   aresetn_rclk : asynchronous reset, active-low
//   sresetn_rclk : synchronous reset, active-low
//   d_i          : bus from the foreign clock domain. The first stage captures it directly.
//   q_o          : synchronized bus, STAGES cycles later
module fifo_sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             pos_rclk,
  input  logic             aresetn_rclk,
  input  logic             sresetn_rclk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else if (!sresetn_rclk) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl
// Read-side pointer controller of an async FIFO. The read pointer is kept in
// binary. Empty, almost-empty and the word count are computed from the
// next-state pointer, so each flag is registered in the same cycle as the read
// that changes it.
//   pos_rclk / aresetn_rclk / sresetn_rclk : read clock, async and sync resets (active-low)
//   fifo_rd_en    : read request. It is ignored while fifo_empty=1.
//   wptr_gray     : write pointer (Gray) from the write domain. It is synchronized here.
//   fifo_empty    : registered empty flag
//   fifo_aempty   : registered flag, rd_count <= AE_THRESH
//   fifo_MEMRADDR : RAM read address. The RAM returns data one cycle after an accepted read.
//   rptr_gray     : registered Gray read pointer for the write domain
//   rd_count      : registered number of words available (0..2**RDEPTH)
//   underflow     : one-cycle pulse after a read request while empty
// Build option: define FIFO_RD_UNDERFLOW_EN to enable the underflow flop.
// When it is undefined, underflow is tied to 0.
module fifo_rd_ptr_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int RDEPTH      = 10,
  parameter int AE_THRESH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pos_rclk,
  input  logic              aresetn_rclk,
  input  logic              sresetn_rclk,
  input  logic              fifo_rd_en,
  input  logic [RDEPTH:0]   wptr_gray,
  output logic              fifo_empty,
  output logic              fifo_aempty,
  output logic [RDEPTH-1:0] fifo_MEMRADDR,
  output logic [RDEPTH:0]   rptr_gray,
  output logic [RDEPTH:0]   rd_count,
  output logic              underflow
);

  localparam int            PW          = ptr_width(RDEPTH);
  localparam logic [PW-1:0] AE_THRESH_W = PW'(AE_THRESH);

  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] wptr_sync_bin;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] rd_count_q, rd_count_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          rd_ok;

  fifo_sync_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .pos_rclk     (pos_rclk),
    .aresetn_rclk (aresetn_rclk),
    .sresetn_rclk (sresetn_rclk),
    .d_i          (wptr_gray),
    .q_o          (wptr_sync)
  );

  assign rd_ok = fifo_rd_en & ~empty_q;

  // Every flag is derived from rptr_d, not rptr_q. A read of the last word
  // therefore raises empty in the very next cycle, so no second read can slip through.
  always_comb begin
    rptr_d        = rptr_q + PW'(rd_ok);
    rptr_gray_d   = PW'(bin2gray(FIFO_PTR_MAX_W'(rptr_d)));
    wptr_sync_bin = PW'(gray2bin(FIFO_PTR_MAX_W'(wptr_sync)));
    rd_count_d    = wptr_sync_bin - rptr_d;
    empty_d       = (rptr_gray_d == wptr_sync);
    aempty_d      = (rd_count_d <= AE_THRESH_W);
  end

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      rptr_q      <= '0;
      rptr_gray_q <= '0;
      rd_count_q  <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
    end else if (!sresetn_rclk) begin
      rptr_q      <= '0;
      rptr_gray_q <= '0;
      rd_count_q  <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
    end else begin
      rptr_q      <= rptr_d;
      rptr_gray_q <= rptr_gray_d;
      rd_count_q  <= rd_count_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      underflow_q <= 1'b0;
    end else if (!sresetn_rclk) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= fifo_rd_en & empty_q;
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

  assign fifo_empty    = empty_q;
  assign fifo_aempty   = aempty_q;
  assign fifo_MEMRADDR = rptr_q[RDEPTH-1:0];
  assign rptr_gray     = rptr_gray_q;
  assign rd_count      = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
module tb_fifo_rd_ptr_ctrl;

  localparam int RDEPTH    = 4;
  localparam int AE_THRESH = 2;
`ifdef FIFO_RD_UNDERFLOW_EN
  localparam logic UF_EN = 1'b1;
`else
  localparam logic UF_EN = 1'b0;
`endif

  logic              pos_rclk = 1'b0;
  logic              aresetn_rclk;
  logic              sresetn_rclk;
  logic              fifo_rd_en;
  logic [RDEPTH:0]   wptr_gray;
  logic              fifo_empty;
  logic              fifo_aempty;
  logic [RDEPTH-1:0] fifo_MEMRADDR;
  logic [RDEPTH:0]   rptr_gray;
  logic [RDEPTH:0]   rd_count;
  logic              underflow;

  fifo_rd_ptr_ctrl #(
    .RDEPTH      (RDEPTH),
    .AE_THRESH   (AE_THRESH),
    .SYNC_STAGES (2)
  ) dut (
    .pos_rclk      (pos_rclk),
    .aresetn_rclk  (aresetn_rclk),
    .sresetn_rclk  (sresetn_rclk),
    .fifo_rd_en    (fifo_rd_en),
    .wptr_gray     (wptr_gray),
    .fifo_empty    (fifo_empty),
    .fifo_aempty   (fifo_aempty),
    .fifo_MEMRADDR (fifo_MEMRADDR),
    .rptr_gray     (rptr_gray),
    .rd_count      (rd_count),
    .underflow     (underflow)
  );

  always #5 pos_rclk = ~pos_rclk;

  typedef struct packed {
    logic [3:0] addr;
    logic [4:0] cnt;
    logic       empty;
    logic       aempty;
    logic       uf;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.addr   = fifo_MEMRADDR;
    o.cnt    = rd_count;
    o.empty  = fifo_empty;
    o.aempty = fifo_aempty;
    o.uf     = underflow;
    return o;
  endfunction

  function automatic obs_t mk(input int addr, input int cnt, input logic e, input logic ae, input logic uf);
    obs_t o;
    o.addr = 4'(addr); o.cnt = 5'(cnt); o.empty = e; o.aempty = ae; o.uf = uf;
    return o;
  endfunction

  task automatic tick();
    @(posedge pos_rclk);
    #1;
  endtask

  // Reset release with wptr=0: empty, almost-empty, zero count and address.
  task automatic test_reset();
    obs_t got, exp;
    aresetn_rclk = 1'b0; sresetn_rclk = 1'b1; fifo_rd_en = 1'b0; wptr_gray = '0;
    repeat (3) tick();
    aresetn_rclk = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(0, 0, 1'b1, 1'b1, 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp || rptr_gray !== 5'd0) begin
        errors++;
        $display("FAIL reset[%0d] got %h gray %h want %h gray 0 (addr,cnt,empty,aempty,uf)", k, got, rptr_gray, exp);
      end
    end
  endtask

  // Five words become visible exactly three clocks after the write pointer moves.
  task automatic test_fill();
    obs_t got, exp;
    wptr_gray = g5(5);
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(k < 3 ? mk(0, 0, 1'b1, 1'b1, 1'b0) : mk(0, 5, 1'b0, 1'b0, 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fill[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", k, got, exp);
      end
    end
  endtask

  // Five reads drain the FIFO. Five more are ignored, and they pulse underflow only when enabled.
  task automatic test_read_drain();
    obs_t got, exp;
    checks++;
    if (fifo_MEMRADDR !== 4'd0) begin
      errors++;
      $display("FAIL drain_first_addr got %0d want 0", fifo_MEMRADDR);
    end
    fifo_rd_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) fifo_rd_en = 1'b0;
      if (k <= 5) sb.push_back(mk(k, 5 - k, k == 5, (5 - k) <= AE_THRESH, 1'b0));
      else        sb.push_back(mk(5, 0, 1'b1, 1'b1, (k <= 10) ? UF_EN : 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drain[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", k, got, exp);
      end
    end
  endtask

  // Reads 20 words through the address wrap. Checks the Gray pointer and the count bound on every step.
  task automatic test_wrap();
    obs_t got, exp;
    int   rptr;
    int   wptr;
    logic [4:0] prev_gray;
    rptr = 5;
    wptr = 5;
    for (int phase = 0; phase < 2; phase++) begin
      wptr = (phase == 0) ? 21 : 25;
      wptr_gray = g5(wptr);
      for (int k = 1; k <= 3; k++) begin
        sb.push_back(k < 3 ? mk(rptr % 16, 0, 1'b1, 1'b1, 1'b0)
                           : mk(rptr % 16, wptr - rptr, 1'b0, (wptr - rptr) <= AE_THRESH, 1'b0));
        tick();
        got = observe(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL wrap_sync[%0d.%0d] got %h want %h (addr,cnt,empty,aempty,uf)", phase, k, got, exp);
        end
      end
      fifo_rd_en = 1'b1;
      while (rptr < wptr) begin
        prev_gray = rptr_gray;
        rptr++;
        sb.push_back(mk(rptr % 16, wptr - rptr, rptr == wptr, (wptr - rptr) <= AE_THRESH, 1'b0));
        tick();
        got = observe(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL wrap_read[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", rptr, got, exp);
        end
        checks++;
        if (rptr_gray !== g5(rptr) || $countones(rptr_gray ^ prev_gray) != 1 || rd_count > 5'd16) begin
          errors++;
          $display("FAIL wrap_gray[%0d] got gray %h cnt %0d want gray %h one-bit step cnt<=16",
                   rptr, rptr_gray, rd_count, g5(rptr));
        end
      end
      fifo_rd_en = 1'b0;
    end
  endtask

  // Async reset in the middle of a burst clears everything immediately. The first read afterwards uses address 0.
  task automatic test_reset_mid();
    obs_t got, exp;
    wptr_gray = g5(32);
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(k < 3 ? mk(9, 0, 1'b1, 1'b1, 1'b0) : mk(9, 7, 1'b0, 1'b0, 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_fill[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", k, got, exp);
      end
    end
    fifo_rd_en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      sb.push_back(mk(9 + k, 7 - k, 1'b0, 1'b0, 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_burst[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", k, got, exp);
      end
    end
    #2 aresetn_rclk = 1'b0;
    #1;
    got = observe(); checks++;
    if (got !== mk(0, 0, 1'b1, 1'b1, 1'b0) || rptr_gray !== 5'd0) begin
      errors++;
      $display("FAIL mid_async got %h gray %h want %h gray 0", got, rptr_gray, mk(0, 0, 1'b1, 1'b1, 1'b0));
    end
    fifo_rd_en = 1'b0;
    wptr_gray  = g5(3);
    tick();
    aresetn_rclk = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(k < 3 ? mk(0, 0, 1'b1, 1'b1, 1'b0) : mk(0, 3, 1'b0, 1'b0, 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_resync[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", k, got, exp);
      end
    end
    fifo_rd_en = 1'b1;
    checks++;
    if (fifo_MEMRADDR !== 4'd0) begin
      errors++;
      $display("FAIL mid_first_addr got %0d want 0", fifo_MEMRADDR);
    end
    sb.push_back(mk(1, 2, 1'b0, 1'b1, 1'b0));
    tick();
    fifo_rd_en = 1'b0;
    got = observe(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_first_read got %h want %h (addr,cnt,empty,aempty,uf)", got, exp);
    end
  endtask

  // Synchronous reset clears the pointer and the synchronizer. The count returns after a fresh resync.
  task automatic test_sync_reset();
    obs_t got, exp;
    sresetn_rclk = 1'b0;
    sb.push_back(mk(0, 0, 1'b1, 1'b1, 1'b0));
    tick();
    sresetn_rclk = 1'b1;
    got = observe(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL sreset got %h want %h (addr,cnt,empty,aempty,uf)", got, exp);
    end
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(k < 3 ? mk(0, 0, 1'b1, 1'b1, 1'b0) : mk(0, 3, 1'b0, 1'b0, 1'b0));
      tick();
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sreset_resync[%0d] got %h want %h (addr,cnt,empty,aempty,uf)", k, got, exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_read_drain();
    test_wrap();
    test_reset_mid();
    test_sync_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ptr_ctrl.md
FIFO_RD_PTR_CTRL -- requirements
Module: fifo_rd_ptr_ctrl

Interface
REQ-001 SHALL have parameter RDEPTH, default 10, read-address width; FIFO depth is 2**RDEPTH words.
REQ-002 SHALL have parameter AE_THRESH, default 2, almost-empty threshold in words.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on the incoming write pointer (minimum 2).
REQ-004 SHALL have ports:
- pos_rclk  in  1  read clock.
- aresetn_rclk  in  1  asynchronous reset, active-low.
- sresetn_rclk  in  1  synchronous reset, active-low.
- fifo_rd_en  in  1  read request from the FWFT stage.
- wptr_gray  in  RDEPTH+1  write pointer (Gray), write-clock domain.
- fifo_empty  out  1  registered empty flag.
- fifo_aempty  out  1  registered almost-empty flag.
- fifo_MEMRADDR  out  RDEPTH  RAM read address.
- rptr_gray  out  RDEPTH+1  registered read pointer (Gray), to write domain.
- rd_count  out  RDEPTH+1  registered words available.
- underflow  out  1  read attempted while empty.
REQ-005 SHALL use reset aresetn_rclk, asynchronous, active-low, and clock pos_rclk.

Function
REQ-006 SHALL pass wptr_gray through a SYNC_STAGES-deep flop chain on pos_rclk to give wptr_sync; no other logic is allowed before the first stage.
REQ-007 SHALL keep rptr_bin, RDEPTH+1 bits wide, and define rd_ok = fifo_rd_en & ~fifo_empty.
REQ-008 SHALL compute rptr_next = rptr_bin + rd_ok, wrapping modulo 2**(RDEPTH+1), and register it every cycle.
REQ-009 SHALL drive fifo_MEMRADDR = rptr_bin[RDEPTH-1:0] directly from the register; the RAM returns data one cycle after rd_ok.
REQ-010 SHALL register rptr_gray = bin2gray(rptr_next); rptr_gray changes by at most one bit per cycle.
REQ-011 SHALL register fifo_empty = (bin2gray(rptr_next) == wptr_sync); empty deasserts no earlier than SYNC_STAGES+1 read clocks after the write pointer changes.
REQ-012 SHALL register rd_count = gray2bin(wptr_sync) - rptr_next, modulo 2**(RDEPTH+1); the range is 0..2**RDEPTH.
REQ-013 SHALL register fifo_aempty = (rd_count_next <= AE_THRESH), with rd_count_next being the value defined in REQ-012.
REQ-014 SHALL ignore fifo_rd_en while fifo_empty=1: the pointer holds and the address holds.
REQ-015 SHALL handle a read on the last word: rptr_next equals the synced write pointer, so fifo_empty=1 in the next cycle with no bubble and no extra read.
REQ-016 SHALL handle pointer wrap: after 2**RDEPTH reads the address wraps to 0 and the MSB toggles; empty and count stay correct across the wrap.
REQ-017 SHALL treat a write-pointer change and a read in the same cycle independently; the count reflects both.

Reset
REQ-018 SHALL, on aresetn_rclk=0 (asynchronous) or sresetn_rclk=0 (synchronous), set rptr_bin=0, all synchronizer flops=0, fifo_empty=1, fifo_aempty=1, fifo_MEMRADDR=0, rptr_gray=0, rd_count=0 and underflow=0.
REQ-019 SHALL, when reset is asserted mid-operation, discard all pointer state immediately; the first read after release addresses location 0.

Configuration
REQ-020 SHALL, with macro FIFO_RD_UNDERFLOW_EN defined, register underflow=1 for exactly one cycle after each cycle where fifo_rd_en=1 and fifo_empty=1.
REQ-021 SHALL, without FIFO_RD_UNDERFLOW_EN, tie underflow to constant 0 and create no underflow flop. All other behaviour is identical with or without the macro.

Structure
REQ-022 SHALL take from shared package fifo_rd_pkg the bin2gray and gray2bin functions and the pointer-width constant, for reuse by the write-side controller.
REQ-023 SHALL instantiate one sub-module, fifo_sync_ff, a parameterised multi-bit flop-chain synchronizer, for REQ-006.

Verification
REQ-024 The bench SHALL cover these scenarios with RDEPTH=4 and AE_THRESH=2:
- Reset release with wptr_gray=0: fifo_empty=1, fifo_aempty=1, rd_count=0, fifo_MEMRADDR=0.
- Set wptr_gray to gray(5) and hold: fifo_empty=0 and rd_count=5 exactly 3 clocks later; fifo_aempty=0.
- With 5 words available, assert fifo_rd_en for 5 cycles: fifo_MEMRADDR steps 0,1,2,3,4; aempty rises when count reaches 2; fifo_empty=1 after the 5th read; then 5 further fifo_rd_en cycles leave the address at 5.
- Same 5 extra reads with FIFO_RD_UNDERFLOW_EN defined: underflow pulses 5 times; without the macro: underflow stays 0.
- Advance write pointer and read through 20 words: fifo_MEMRADDR wraps 15->0; rptr_gray shows single-bit changes; rd_count never exceeds 16.
- Assert aresetn_rclk=0 mid-burst with 7 words pending: outputs return to reset values asynchronously; the next read after release uses address 0.
